// File: rtl/trace_buffer.sv
// trace_buffer: timestamped circular FIFO that captures trace records.
// Each accepted record is stored together with the free-running cycle
// counter value of its capture cycle. When the FIFO is full and the head
// is not being consumed, the incoming record is dropped and accounted for
// in a sticky overflow flag plus a saturating drop counter.
module trace_buffer #(
   parameter int REC_WIDTH = 96,
   parameter int DEPTH     = 16,
   parameter int TS_WIDTH  = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          trace_ready_i,
   input  logic [REC_WIDTH-1:0]          trace_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [TS_WIDTH+REC_WIDTH-1:0] out_data_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic                          overflow_o,
   output logic [15:0]                   drop_count_o,
   input  logic                          clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TS_WIDTH + REC_WIDTH;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Storage is deliberately not reset; occupancy and pointers define validity.
   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [TS_WIDTH-1:0] ts;
   logic                overflow;
   logic [15:0]         drop_count;

   logic full;
   logic pop;
   logic push;
   logic drop;

   // Decide this cycle's pop, accepted push and dropped push from registered occupancy.
   always_comb begin
      full = (count == FULL_COUNT);
      pop  = (count != '0) && out_ready_i;
      push = trace_ready_i && (!full || pop);
      drop = trace_ready_i && full && !pop;
   end

   // Free-running timestamp; the first cycle after reset reads as zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_WIDTH'(1);
      end
   end

   // Write the {timestamp, record} entry at the write pointer on accepted pushes.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {ts, trace_i};
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Overflow accounting; a clear coinciding with a drop leaves exactly one drop recorded.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow   <= 1'b0;
         drop_count <= 16'd0;
      end else if (clr_i) begin
         overflow   <= drop;
         drop_count <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= (drop_count == 16'hFFFF) ? 16'hFFFF : drop_count + 16'd1;
      end else begin
         overflow   <= overflow;
         drop_count <= drop_count;
      end
   end

   assign out_valid_o  = (count != '0);
   assign out_data_o   = mem[rd_ptr];
   assign count_o      = count;
   assign overflow_o   = overflow;
   assign drop_count_o = drop_count;

endmodule

// File: tb/tb_trace_buffer.sv
// Testbench for trace_buffer: a driver issues directed and random stimulus
// and keeps a queue-based reference model; expected head entries are pushed
// into a scoreboard queue which a separate monitor drains whenever the DUT
// hands out an entry.
module tb_trace_buffer;

   localparam int RW = 96;
   localparam int D  = 16;
   localparam int TW = 32;
   localparam int EW = TW + RW;
   localparam int CW = $clog2(D) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          trace_ready_i = 1'b0;
   logic [RW-1:0] trace_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [EW-1:0] out_data_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;
   logic [15:0]   drop_count_o;
   logic          clr_i = 1'b0;

   trace_buffer #(.REC_WIDTH(RW), .DEPTH(D), .TS_WIDTH(TW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .trace_ready_i(trace_ready_i), .trace_i(trace_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .count_o(count_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o), .clr_i(clr_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state (abstract: an occupancy number, a cycle index, drop statistics)
   logic [EW-1:0] exp_q[$];
   int            m_count;
   logic [TW-1:0] m_ts;
   logic          m_ovf;
   int            m_drop;
   logic [RW-1:0] first_rec;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake observed on the output side must match the scoreboard head
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", out_data_o, '0);
            if (out_data_o == '0) begin
               n_err++;
               $display("FAIL unexpected_output: got entry with empty scoreboard at %0t", $time);
            end
         end else begin
            chk("out_data", out_data_o, exp_q.pop_front());
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      m_count = 0;
      m_ts    = '0;
      m_ovf   = 1'b0;
      m_drop  = 0;
   endtask

   // Reset asserted for a cycle and released just after an edge.
   task automatic reset_dut();
      rst_i = 1'b1;
      trace_ready_i = 1'b0; out_ready_i = 1'b0; clr_i = 1'b0;
      @(posedge clk_i); #1;
      model_reset();
      rst_i = 1'b0;
   endtask

   // One cycle: check visible state against the model, drive, advance model.
   task automatic step(input logic tr, input logic [RW-1:0] rec, input logic ordy, input logic clr);
      logic pop_m, acc_m, drop_m;
      chk("count", EW'(count_o), EW'(m_count));
      chk("out_valid", EW'(out_valid_o), EW'(m_count != 0));
      chk("overflow", EW'(overflow_o), EW'(m_ovf));
      chk("drop_count", EW'(drop_count_o), EW'(m_drop));
      trace_ready_i = tr; trace_i = rec; out_ready_i = ordy; clr_i = clr;
      pop_m  = (m_count > 0) && ordy;
      acc_m  = tr && ((m_count < D) || pop_m);
      drop_m = tr && !acc_m;
      if (acc_m) exp_q.push_back({m_ts, rec});
      m_count = m_count + (acc_m ? 1 : 0) - (pop_m ? 1 : 0);
      if (clr) begin
         m_ovf  = drop_m;
         m_drop = drop_m ? 1 : 0;
      end else if (drop_m) begin
         m_ovf  = 1'b1;
         m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
      end
      @(posedge clk_i); #1;
      m_ts = m_ts + 1;
      trace_ready_i = 1'b0; out_ready_i = 1'b0; clr_i = 1'b0;
   endtask

   function automatic logic [RW-1:0] rnd_rec();
      return {$urandom, $urandom, $urandom};
   endfunction

   // Consume until empty, bounded; then the scoreboard must have been emptied too.
   task automatic drain();
      int budget = 200;
      while (m_count > 0 && budget > 0) begin
         step(1'b0, '0, 1'b1, 1'b0);
         budget--;
      end
      step(1'b0, '0, 1'b0, 1'b0);
      chk("drain_scoreboard_empty", EW'(exp_q.size()), '0);
   endtask

   initial begin
      logic [RW-1:0] rec_a;
      model_reset();
      reset_dut();

      // Single record at timestamp 5, visible one cycle later
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
      rec_a = rnd_rec();
      step(1'b1, rec_a, 1'b1, 1'b0);
      chk("ts5_valid", EW'(out_valid_o), EW'(1));
      chk("ts5_data", out_data_o, {32'd5, rec_a});
      step(1'b0, '0, 1'b1, 1'b0);
      chk("ts5_count_after_pop", EW'(count_o), '0);

      // 17 pushes into a 16-deep FIFO with no consumer
      reset_dut();
      for (int i = 0; i < 17; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
      chk("full_count", EW'(count_o), EW'(16));
      chk("full_overflow", EW'(overflow_o), EW'(1));
      chk("full_drops", EW'(drop_count_o), EW'(1));
      drain();

      // Full FIFO with simultaneous push and pop
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         logic [RW-1:0] r;
         r = rnd_rec();
         if (i == 0) first_rec = r;
         step(1'b1, r, 1'b0, 1'b0);
      end
      chk("pp_head_first", out_data_o, {32'd0, first_rec});
      step(1'b1, rnd_rec(), 1'b1, 1'b0);
      chk("pp_count_stays", EW'(count_o), EW'(16));
      chk("pp_no_drop", EW'(drop_count_o), '0);
      drain();

      // 40 pushes with a consumer always ready: pointers wrap twice
      reset_dut();
      for (int i = 0; i < 40; i++) step(1'b1, rnd_rec(), 1'b1, 1'b0);
      drain();
      chk("wrap_drops", EW'(drop_count_o), '0);

      // Clear coincident with a drop, then clear alone
      reset_dut();
      for (int i = 0; i < 17; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
      step(1'b1, rnd_rec(), 1'b0, 1'b1);
      chk("clr_drop_count", EW'(drop_count_o), EW'(1));
      chk("clr_drop_ovf", EW'(overflow_o), EW'(1));
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_alone_count", EW'(drop_count_o), '0);
      chk("clr_alone_ovf", EW'(overflow_o), '0);
      chk("clr_keeps_fifo", EW'(count_o), EW'(16));
      drain();

      // Asynchronous reset in the middle of a clock period with 5 entries stored
      reset_dut();
      for (int i = 0; i < 5; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
      chk("pre_rst_count", EW'(count_o), EW'(5));
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_count", EW'(count_o), '0);
      chk("async_rst_valid", EW'(out_valid_o), '0);
      exp_q.delete();
      @(posedge clk_i); #1;
      model_reset();
      rst_i = 1'b0;
      step(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic with occasional clears
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 99) < 60, rnd_rec(), $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 4);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter REC_WIDTH, default 96, meaning width of one flattened trace record.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter TS_WIDTH, default 32, meaning timestamp width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port trace_ready_i  input  1  trace unit asserts for one cycle per completed record.
REQ-007 SHALL have port trace_i  input  REC_WIDTH  record payload, valid when trace_ready_i=1.
REQ-008 SHALL have port out_valid_o  output  1  head entry available.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts head.
REQ-010 SHALL have port out_data_o  output  TS_WIDTH+REC_WIDTH  {timestamp, record} of head entry.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow_o  output  1  sticky: at least one record dropped since last clear.
REQ-013 SHALL have port drop_count_o  output  16  number of dropped records, saturating.
REQ-014 SHALL have port clr_i  input  1  synchronous clear of overflow_o and drop_count_o.

Function
REQ-015 SHALL run a free-running TS_WIDTH-bit cycle counter, +1 every cycle, wrapping from all-ones to 0.
REQ-016 SHALL, on a cycle with trace_ready_i=1 and entry accepted, store {counter value of that cycle, trace_i}.
REQ-017 SHALL implement a circular FIFO with rd/wr pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-018 SHALL drive out_valid_o = (count_o != 0) and out_data_o = entry at rd pointer, both from registered state only.
REQ-019 SHALL pop the head on a cycle where out_valid_o=1 and out_ready_i=1; out_ready_i with out_valid_o=0 has no effect.
REQ-020 SHALL have push-to-out_valid_o latency of exactly 1 cycle (no combinational fall-through).
REQ-021 SHALL, when count_o < DEPTH at cycle start, accept every push.
REQ-022 SHALL, when count_o = DEPTH and a pop occurs the same cycle, accept the push; count_o stays DEPTH.
REQ-023 SHALL, when count_o = DEPTH without pop, drop the push, set overflow_o, increment drop_count_o.
REQ-024 SHALL saturate drop_count_o at 16'hFFFF.
REQ-025 SHALL update count_o: +1 push only, -1 pop only, unchanged for both or neither.
REQ-026 SHALL, when clr_i=1, zero drop_count_o and overflow_o; a drop in the same cycle yields drop_count_o=1, overflow_o=1.
REQ-027 SHALL leave FIFO contents and pointers unaffected by clr_i.

Reset
REQ-028 SHALL, on rst_i=1, immediately set pointers, count_o, counter, drop_count_o to 0 and overflow_o, out_valid_o to 0, regardless of clock.
REQ-029 SHALL discard all stored entries on reset mid-operation; storage array need not be cleared.
REQ-030 SHALL, after rst_i deasserts, stamp the first post-reset cycle with timestamp 0.

Verification
REQ-031 SHALL test: reset, push rec A at timestamp 5, out_ready_i=1 -> out_valid_o=1 at cycle 6 with {32'd5, A}, count_o returns to 0 after pop.
REQ-032 SHALL test: out_ready_i=0, 17 pushes with DEPTH=16 -> count_o=16, overflow_o=1, drop_count_o=1, 17th record absent from output.
REQ-033 SHALL test: full FIFO, simultaneous push and pop -> count_o stays 16, popped head is 1st record, new record emerges 16th.
REQ-034 SHALL test: 40 pushes with out_ready_i=1 every cycle -> pointers wrap twice, all 40 records out in order, drop_count_o=0.
REQ-035 SHALL test: clr_i coincident with a drop -> drop_count_o=1, overflow_o=1; clr_i alone next cycle -> both 0.
REQ-036 SHALL test: rst_i pulse asserted mid-clock with 5 entries -> count_o=0, out_valid_o=0 before next edge.
